// File: rtl/nmi2apb_pkg.sv
// Shared types and helpers for the NMI-to-APB crossbar.
// FSM state encoding, error counter width and the address window match.
package nmi2apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int unsigned ERR_CNT_W = 8;
    localparam int unsigned MAX_AW    = 64;

    // Callers zero-extend narrower addresses to MAX_AW.
    function automatic logic decode_hit(input logic [MAX_AW-1:0] addr,
                                        input logic [MAX_AW-1:0] base,
                                        input logic [MAX_AW-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/nmi2apb_decoder.sv
// Combinational address decoder: one-hot hit vector with lowest-index priority
// plus a miss flag when no window matches.
module nmi2apb_decoder
    import nmi2apb_pkg::*;
#(
    parameter int unsigned           N_SLV    = 4,
    parameter int unsigned           AW       = 32,
    parameter logic [N_SLV*AW-1:0]   SLV_BASE = '0,
    parameter logic [N_SLV*AW-1:0]   SLV_MASK = '0
) (
    input  logic [AW-1:0]    addr_i,
    output logic [N_SLV-1:0] hit_o,
    output logic             miss_o
);

    logic found;

    always_comb begin
        hit_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (!found && decode_hit(MAX_AW'(addr_i),
                                     MAX_AW'(SLV_BASE[i*AW +: AW]),
                                     MAX_AW'(SLV_MASK[i*AW +: AW]))) begin
                hit_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        miss_o = !found;
    end

endmodule

// File: rtl/nmi2apb_xbar.sv
// PicoRV32 native-memory-interface master fanned out to N_SLV APB4 completers,
// with decode-miss, PSLVERR and wait-state timeout reporting.
module nmi2apb_xbar
    import nmi2apb_pkg::*;
#(
    parameter int unsigned         N_SLV    = 4,
    parameter int unsigned         AW       = 32,
    parameter int unsigned         DW       = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = '0,
    parameter int unsigned         TIMEOUT  = 255,
    parameter logic [31:0]         ERR_DATA = 32'hDEADBEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mem_valid_i,
    output logic                 mem_ready_o,
    input  logic [AW-1:0]        mem_addr_i,
    input  logic [DW-1:0]        mem_wdata_i,
    input  logic [DW/8-1:0]      mem_wstrb_i,
    output logic [DW-1:0]        mem_rdata_o,
    output logic [N_SLV-1:0]     psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [AW-1:0]        paddr_o,
    output logic [DW-1:0]        pwdata_o,
    output logic [DW/8-1:0]      pstrb_o,
    input  logic [N_SLV-1:0]     pready_i,
    input  logic [N_SLV*DW-1:0]  prdata_i,
    input  logic [N_SLV-1:0]     pslverr_i,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int unsigned    TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [DW-1:0]  ERR_DW = DW'(ERR_DATA);

    state_e               state_q, state_d;
    logic [N_SLV-1:0]     psel_d;
    logic                 penable_d, pwrite_d;
    logic [AW-1:0]        paddr_d;
    logic [DW-1:0]        pwdata_d;
    logic [DW/8-1:0]      pstrb_d;
    logic                 ready_d, err_d;
    logic [DW-1:0]        rdata_d;
    logic [ERR_CNT_W-1:0] cnt_d;
    logic [TW-1:0]        wait_q, wait_d;

    logic [N_SLV-1:0]     hit;
    logic                 miss;
    logic                 sel_rdy, sel_err;
    logic [DW-1:0]        sel_rdata;

    // Decoding the incoming address lets psel_o be registered on the capture edge.
    nmi2apb_decoder #(
        .N_SLV    (N_SLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decoder (
        .addr_i (mem_addr_i),
        .hit_o  (hit),
        .miss_o (miss)
    );

    always_comb begin
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (psel_o[i]) begin
                sel_rdy   = sel_rdy | pready_i[i];
                sel_err   = sel_err | pslverr_i[i];
                sel_rdata = sel_rdata | prdata_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_o;
        penable_d = penable_o;
        pwrite_d  = pwrite_o;
        paddr_d   = paddr_o;
        pwdata_d  = pwdata_o;
        pstrb_d   = pstrb_o;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        rdata_d   = '0;
        cnt_d     = err_cnt_o;
        wait_d    = wait_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_valid_i) begin
                    if (miss) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = ERR_DW;
                    end else begin
                        state_d   = ST_SETUP;
                        psel_d    = hit;
                        penable_d = 1'b0;
                        pwrite_d  = |mem_wstrb_i;
                        paddr_d   = mem_addr_i;
                        pwdata_d  = mem_wdata_i;
                        pstrb_d   = mem_wstrb_i;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ST_ACCESS: begin
                if (sel_rdy || (TIMEOUT != 0 && 32'(wait_q) == TIMEOUT - 1)) begin
                    state_d   = ST_RESP;
                    ready_d   = 1'b1;
                    err_d     = !sel_rdy || sel_err;
                    rdata_d   = (!sel_rdy || sel_err) ? ERR_DW : sel_rdata;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = '0;
                    pwdata_d  = '0;
                    pstrb_d   = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Counter advances on the edge that enters RESP, so it is current while err_o is high.
        if (err_d && err_cnt_o != '1) begin
            cnt_d = err_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            psel_o      <= '0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
            err_o       <= 1'b0;
            err_cnt_o   <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            psel_o      <= psel_d;
            penable_o   <= penable_d;
            pwrite_o    <= pwrite_d;
            paddr_o     <= paddr_d;
            pwdata_o    <= pwdata_d;
            pstrb_o     <= pstrb_d;
            mem_ready_o <= ready_d;
            mem_rdata_o <= rdata_d;
            err_o       <= err_d;
            err_cnt_o   <= cnt_d;
            wait_q      <= wait_d;
        end
    end

endmodule
